quiz_judge: RTL
===============

Name: quiz_judge

Overview:
- Consumer of the settings block's outputs: maxtime (BCD seconds), maxuser, scorejia, scorejian, endset.
- Runs one buzzer round: host start, BCD countdown, first-press lockout, host verdict, per-player score update.
- Sits between the settings block, debounced player/host buttons, and the display/LED driver.

Parameters:
- NUSER, 4, number of player buzzer inputs and score registers.
- SCORE_MAX, 99, score saturation ceiling (two display digits).
- SCORE_INIT, 10, score loaded at reset and on clr_score.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-clk 1 Hz enable pulse.
- endset  in  1  1 = settings closed; start accepted only when 1.
- maxtime  in  8  BCD countdown preset, {tens,ones}.
- maxuser  in  4  active players; values 0 and >NUSER are treated as NUSER.
- scorejia  in  4  points added on a correct answer.
- scorejian  in  4  points deducted on a wrong answer.
- start  in  1  host start button (level, async).
- judge_ok  in  1  host "correct" button (level, async).
- judge_bad  in  1  host "wrong" button (level, async).
- clr_score  in  1  host score-clear button (level, async).
- buzz  in  NUSER  player buttons (level, async); bit i = player i.
- state  out  2  00 IDLE, 01 RUN, 10 LOCK, 11 TIMEOUT.
- winner  out  NUSER  one-hot locked player; 0 when none.
- countdown  out  8  live BCD remaining time.
- scores  out  8*NUSER  binary score per player; player i at [8i+7:8i].
- beep  out  1  one-clk pulse on lock and on timeout.

Behaviour:
- Reset (rst=0, async): state=IDLE, winner=0, countdown=00, scores=SCORE_INIT each, beep=0, synchronizer and edge flops cleared.
- Inputs: every button passes through a 2-FF synchronizer plus a rising-edge detector. Events are one-clk pulses, 3 clk after the pin edge. tick is already synchronous.
- IDLE:
  - start event with endset=1 -> RUN; countdown<=maxtime; winner<=0.
  - start event with endset=0 -> ignored.
  - buzz, judge_ok and judge_bad events -> ignored.
- RUN:
  - Eligible set = buzz events with index < effective maxuser.
  - Non-empty eligible set -> LOCK next clk; winner = lowest eligible index (simultaneous presses: lowest wins); beep=1 for one clk.
  - Otherwise, on tick: countdown decrements in BCD. Ones digit 0 -> 9 with tens-1. Then, if the new value is 00 -> TIMEOUT, beep pulse.
  - Buzz and tick in the same clk: the buzz wins and the countdown is not decremented.
  - maxtime=00 at start: RUN for one clk, then TIMEOUT; a buzz in that clk still locks.
  - Invalid BCD preset digits (>9): the digit is clamped to 9 on load.
- LOCK:
  - countdown freezes.
  - judge_ok event: winner's score += scorejia, saturating at SCORE_MAX; -> IDLE; winner held for display until the next start.
  - judge_bad event: score -= scorejian, saturating at 0; -> IDLE; winner held.
  - judge_ok and judge_bad in the same clk: judge_bad takes priority.
  - start in LOCK: ignored.
- TIMEOUT:
  - start event with endset=1 -> RUN, preset reloaded.
  - judge_ok / judge_bad events -> IDLE, no score change.
- clr_score event (any state): all scores<=SCORE_INIT; state<=IDLE; winner<=0; countdown<=00. Takes priority over every other event in the same clk.
- Score arithmetic: 9-bit intermediate, then clamp. Score updates land 1 clk after the judge event.
- Settings sampling: maxtime and maxuser are sampled only at the start event. scorejia and scorejian are sampled at the judge event.
- Asserting rst mid-round aborts the round immediately; scores return to SCORE_INIT.

Test Plan:
- Reset, then start with endset=1, maxtime=8'h30 -> state=RUN, countdown=30; after 1 tick 29; after 10 ticks 20; after 30 ticks state=TIMEOUT, countdown=00, beep pulse.
- RUN, maxuser=4, buzz=4'b0110 in the same clk -> winner=4'b0010, state=LOCK, beep; countdown frozen across further ticks.
- LOCK winner=player1 (score 10), scorejia=5, judge_ok -> score1=15, state=IDLE, other scores unchanged. Repeat at score 97 -> 99 (saturate).
- LOCK winner=player0 (score 2), scorejian=4, judge_bad -> score0=0 (floor). judge_ok+judge_bad together -> deduction applied.
- maxuser=2, RUN, buzz=4'b1000 -> ignored, stays RUN. Start with endset=0 in IDLE -> stays IDLE.
- Mid-RUN: clr_score -> all scores=10, state=IDLE. Mid-LOCK: rst low -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/quiz_judge.sv
// Buzzer-round judge: host start, BCD countdown, first-press lockout, host verdict and
// saturating per-player score update. All buttons are synchronized and edge-detected.
module quiz_judge #(
   parameter int unsigned NUSER      = 4,
   parameter int unsigned SCORE_MAX  = 99,
   parameter int unsigned SCORE_INIT = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  endset,
   input  logic [7:0]            maxtime,
   input  logic [3:0]            maxuser,
   input  logic [3:0]            scorejia,
   input  logic [3:0]            scorejian,
   input  logic                  start,
   input  logic                  judge_ok,
   input  logic                  judge_bad,
   input  logic                  clr_score,
   input  logic [NUSER-1:0]      buzz,
   output logic [1:0]            state,
   output logic [NUSER-1:0]      winner,
   output logic [7:0]            countdown,
   output logic [8*NUSER-1:0]    scores,
   output logic                  beep
);

   localparam int unsigned NB = NUSER + 4;

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StRun     = 2'b01,
      StLock    = 2'b10,
      StTimeout = 2'b11
   } state_e;

   state_e                    state_q, state_d;
   logic [NUSER-1:0]          winner_q, winner_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [NUSER-1:0][7:0]     scores_q, scores_d;
   logic [NUSER-1:0]          users_q, users_d;
   logic                      beep_q, beep_d;

   logic [NB-1:0]             btn_raw;
   logic [NB-1:0]             sync1_q, sync2_q, sync3_q;
   logic [NB-1:0]             ev;
   logic                      ev_start, ev_ok, ev_bad, ev_clr;
   logic [NUSER-1:0]          ev_buzz;

   logic [NUSER-1:0]          user_mask;
   logic [NUSER-1:0]          first;
   logic                      found;
   int unsigned               eff_users;
   logic [7:0]                load_val;
   logic [7:0]                cnt_dec;
   logic [7:0]                win_score;
   logic [8:0]                sum;
   logic [8:0]                diff;
   logic [7:0]                score_up;
   logic [7:0]                score_dn;

   assign btn_raw  = {clr_score, judge_bad, judge_ok, start, buzz};
   assign ev       = sync2_q & ~sync3_q;
   assign ev_buzz  = ev[NUSER-1:0];
   assign ev_start = ev[NUSER];
   assign ev_ok    = ev[NUSER+1];
   assign ev_bad   = ev[NUSER+2];
   assign ev_clr   = ev[NUSER+3];

   assign state     = state_q;
   assign winner    = winner_q;
   assign countdown = cnt_q;
   assign scores    = scores_q;
   assign beep      = beep_q;

   always_comb begin
      // Player-count mask is frozen at start; 0 or out-of-range means all players.
      if (maxuser == 4'd0 || 32'(maxuser) > NUSER) begin
         eff_users = NUSER;
      end else begin
         eff_users = 32'(maxuser);
      end
      user_mask = '0;
      for (int unsigned i = 0; i < NUSER; i++) begin
         user_mask[i] = (i < eff_users);
      end

      load_val[7:4] = (maxtime[7:4] > 4'd9) ? 4'd9 : maxtime[7:4];
      load_val[3:0] = (maxtime[3:0] > 4'd9) ? 4'd9 : maxtime[3:0];

      if (cnt_q[3:0] == 4'd0) begin
         cnt_dec = {cnt_q[7:4] - 4'd1, 4'd9};
      end else begin
         cnt_dec = {cnt_q[7:4], cnt_q[3:0] - 4'd1};
      end

      first = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUSER; i++) begin
         if (ev_buzz[i] && users_q[i] && !found) begin
            first[i] = 1'b1;
            found    = 1'b1;
         end
      end

      win_score = '0;
      for (int unsigned i = 0; i < NUSER; i++) begin
         if (winner_q[i]) begin
            win_score = win_score | scores_q[i];
         end
      end
      sum      = {1'b0, win_score} + {5'b0, scorejia};
      diff     = {1'b0, win_score} - {5'b0, scorejian};
      score_up = (sum > 9'(SCORE_MAX)) ? 8'(SCORE_MAX) : sum[7:0];
      score_dn = diff[8] ? 8'd0 : diff[7:0];

      state_d  = state_q;
      winner_d = winner_q;
      cnt_d    = cnt_q;
      scores_d = scores_q;
      users_d  = users_q;
      beep_d   = 1'b0;

      if (ev_clr) begin
         for (int unsigned i = 0; i < NUSER; i++) begin
            scores_d[i] = 8'(SCORE_INIT);
         end
         state_d  = StIdle;
         winner_d = '0;
         cnt_d    = '0;
      end else begin
         case (state_q)
            StIdle, StTimeout: begin
               if (ev_start && endset) begin
                  state_d  = StRun;
                  cnt_d    = load_val;
                  winner_d = '0;
                  users_d  = user_mask;
               end else if (state_q == StTimeout && (ev_ok || ev_bad)) begin
                  state_d = StIdle;
               end
            end
            StRun: begin
               if (found) begin
                  state_d  = StLock;
                  winner_d = first;
                  beep_d   = 1'b1;
               end else if (cnt_q == 8'h00) begin
                  state_d = StTimeout;
                  beep_d  = 1'b1;
               end else if (tick) begin
                  cnt_d = cnt_dec;
                  if (cnt_dec == 8'h00) begin
                     state_d = StTimeout;
                     beep_d  = 1'b1;
                  end
               end
            end
            StLock: begin
               if (ev_bad || ev_ok) begin
                  for (int unsigned i = 0; i < NUSER; i++) begin
                     if (winner_q[i]) begin
                        scores_d[i] = ev_bad ? score_dn : score_up;
                     end
                  end
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         sync3_q  <= '0;
         state_q  <= StIdle;
         winner_q <= '0;
         cnt_q    <= '0;
         users_q  <= '0;
         beep_q   <= 1'b0;
         for (int unsigned i = 0; i < NUSER; i++) begin
            scores_q[i] <= 8'(SCORE_INIT);
         end
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         sync3_q  <= sync2_q;
         state_q  <= state_d;
         winner_q <= winner_d;
         cnt_q    <= cnt_d;
         users_q  <= users_d;
         beep_q   <= beep_d;
         scores_q <= scores_d;
      end
   end

endmodule
